output_arbiter: RTL and testbench
=================================

OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, number of upstream input ports arbitrated.
REQ-002 Parameter WIDTH, default 16, flit width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  NUM_IN  per-port "front flit present" (driven by each input port's read_valid_o).
REQ-006 data_i  input  NUM_IN*WIDTH  per-port front flit; port k occupies bits [k*WIDTH +: WIDTH].
REQ-007 shift_o  output  NUM_IN  per-port pop strobe, at most one bit set per cycle.
REQ-008 data_o  output  WIDTH  registered outgoing flit.
REQ-009 valid_o  output  1  data_o holds a flit not yet accepted downstream.
REQ-010 ready_i  input  1  downstream accepts data_o this cycle when valid_o=1.
REQ-011 grant_o  output  clog2(NUM_IN)  index of the currently owning/last granted port.
REQ-012 locked_o  output  1  high while a multi-flit packet holds the output.
REQ-013 proto_err_o  output  1  one-cycle pulse on a flit-type violation.

Function
REQ-014 Flit type is data[WIDTH-1:WIDTH-2]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
REQ-015 Output register is loadable in a cycle when valid_o=0 or ready_i=1 ("load_ok").
REQ-016 A transfer from port k occurs in a cycle iff load_ok, port k is selected and valid_i[k]=1; then shift_o[k]=1 (combinational, same cycle) and data_o<=data_i[k], valid_o<=1 on the next edge.
REQ-017 If load_ok and no transfer, valid_o<=0 on the next edge; data_o holds its value.
REQ-018 If valid_o=1 and ready_i=0, data_o and valid_o hold and all shift_o stay 0.
REQ-019 FSM states: IDLE, LOCKED.
REQ-020 IDLE: eligible ports are those with valid_i=1 and front flit HEAD or SINGLE; selection is round-robin starting at rr_ptr, wrapping NUM_IN-1 -> 0.
REQ-021 IDLE, transfer of HEAD from port k: next state LOCKED, owner<=k, rr_ptr<=(k+1) mod NUM_IN.
REQ-022 IDLE, transfer of SINGLE from port k: stay IDLE, rr_ptr<=(k+1) mod NUM_IN.
REQ-023 IDLE: a port with valid_i=1 and front flit BODY or TAIL is never shifted; proto_err_o pulses in any cycle such a port exists and no eligible port exists.
REQ-024 LOCKED: only owner is selected; other ports receive no shift regardless of valid_i.
REQ-025 LOCKED, owner valid_i=0: stall, no transfer, remain LOCKED (no timeout).
REQ-026 LOCKED, transfer of BODY: remain LOCKED.
REQ-027 LOCKED, transfer of TAIL: next state IDLE; new arbitration earliest next cycle.
REQ-028 LOCKED, owner front flit HEAD or SINGLE: not shifted, proto_err_o pulses, remain LOCKED.
REQ-029 locked_o=1 exactly when state=LOCKED; grant_o=owner in LOCKED, last transfer port in IDLE.
REQ-030 Throughput: one flit per cycle when ready_i=1 continuously and the selected port stays valid.
REQ-031 Latency: flit appears on data_o one cycle after its shift_o pulse.
REQ-032 proto_err_o is registered-free combinational decode, 0 whenever rst=1.

Reset
REQ-033 While rst=1 on a rising edge: state<=IDLE, rr_ptr<=0, owner<=0, grant_o<=0, valid_o<=0, data_o<=0.
REQ-034 While rst=1, shift_o=0 and proto_err_o=0 combinationally; no flit consumed.
REQ-035 rst asserted mid-packet abandons the lock; any flit in data_o is discarded.

Verification
REQ-036 Reset, then port 2 SINGLE 0xC0AA, ready_i=1 -> shift_o=4'b0100 cycle 1, data_o=0xC0AA valid_o=1 cycle 2, rr_ptr=3, locked_o=0.
REQ-037 Ports 0..3 all present SINGLE continuously, rr_ptr=0, ready_i=1 -> grant order 0,1,2,3,0, one flit per cycle.
REQ-038 Port 1 HEAD 0x8001, BODY 0x0002, TAIL 0x4003 while port 0 holds HEAD -> port 1 flits sent back-to-back, port 0 shift_o stays 0 until cycle after TAIL, then port 0 granted.
REQ-039 Valid_o=1 with ready_i=0 for 3 cycles mid-packet -> data_o stable, shift_o=0 all cycles; resumes on ready_i=1 with no flit loss or duplication.
REQ-040 IDLE with only port 3 front flit BODY 0x0055 -> proto_err_o=1, shift_o=0, valid_o stays 0.
REQ-041 rst pulsed after HEAD sent, before TAIL -> locked_o=0, valid_o=0, data_o=0 next cycle; new HEAD from any port granted afterwards starting at port 0.

Source files
------------

// File: rtl/output_arbiter.sv
// Output-port arbiter: round-robin among upstream ports for HEAD/SINGLE flits,
// then holds the output for the owning port until its TAIL passes.
// Registered output stage with valid/ready handshake downstream.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no packet in flight; arbitrate HEAD/SINGLE fronts round-robin
// LOCKED | multi-flit packet owns the output; only owner is popped
module output_arbiter #(
  parameter  int NUM_IN = 4,
  parameter  int WIDTH  = 16,
  localparam int IW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       valid_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  output logic [NUM_IN-1:0]       shift_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [IW-1:0]           grant_o,
  output logic                    locked_o,
  output logic                    proto_err_o
);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;

  logic              load_ok;
  logic              sel_found;
  logic              any_bad;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     sel_next;
  logic [WIDTH-1:0]  sel_flit;
  logic [1:0]        sel_type;
  int                idx;

  // Arbitration, handshake and next-state decode.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    data_d      = data_q;
    valid_d     = valid_q;
    shift_o     = '0;
    proto_err_o = 1'b0;
    sel         = '0;
    sel_found   = 1'b0;
    any_bad     = 1'b0;
    idx         = 0;

    load_ok = !valid_q || ready_i;

    if (state_q == ST_IDLE) begin
      // The MSB of the flit type is set exactly for HEAD and SINGLE.
      for (int i = 0; i < NUM_IN; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!sel_found && valid_i[idx] && data_i[idx*WIDTH + WIDTH-1]) begin
          sel_found = 1'b1;
          sel       = IW'(idx);
        end
        if (valid_i[i] && !data_i[i*WIDTH + WIDTH-1]) any_bad = 1'b1;
      end
      proto_err_o = any_bad && !sel_found;
    end else begin
      // Owner may only send BODY/TAIL; a HEAD/SINGLE front is a violation.
      sel         = owner_q;
      sel_found   = valid_i[owner_q] && !data_i[int'(owner_q)*WIDTH + WIDTH-1];
      proto_err_o = valid_i[owner_q] &&  data_i[int'(owner_q)*WIDTH + WIDTH-1];
    end

    sel_flit = data_i[int'(sel)*WIDTH +: WIDTH];
    sel_type = sel_flit[WIDTH-1:WIDTH-2];
    sel_next = (int'(sel) == NUM_IN-1) ? '0 : sel + 1'b1;

    if (load_ok) begin
      if (sel_found) begin
        shift_o[sel] = 1'b1;
        data_d       = sel_flit;
        valid_d      = 1'b1;
        grant_d      = sel;
        if (state_q == ST_IDLE) begin
          rr_ptr_d = sel_next;
          if (sel_type == FT_HEAD) begin
            state_d = ST_LOCKED;
            owner_d = sel;
          end
        end else if (sel_type == FT_TAIL) begin
          state_d = ST_IDLE;
        end
      end else begin
        valid_d = 1'b0;
      end
    end

    if (rst) begin
      shift_o     = '0;
      proto_err_o = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign locked_o = (state_q == ST_LOCKED);
  assign grant_o  = locked_o ? owner_q : grant_q;

  // FT_BODY / FT_SINGLE document the encoding; only MSB and TAIL/HEAD are decoded.
  logic unused_ft;
  assign unused_ft = ^{FT_BODY, FT_SINGLE};

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: reset, single transfer, round-robin order,
// packet locking, backpressure, protocol errors and mid-packet reset.
module tb_output_arbiter;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 16;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN-1:0]       valid_i;
  logic [NUM_IN*WIDTH-1:0] data_i;
  logic [NUM_IN-1:0]       shift_o;
  logic [WIDTH-1:0]        data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [1:0]              grant_o;
  logic                    locked_o;
  logic                    proto_err_o;

  int n_checks = 0;
  int n_errors = 0;

  output_arbiter #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .shift_o     (shift_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .grant_o     (grant_o),
    .locked_o    (locked_o),
    .proto_err_o (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic [WIDTH-1:0] v);
    data_i[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    logic [3:0] exp_order [5];
    exp_order[0] = 4'd0; exp_order[1] = 4'd1; exp_order[2] = 4'd2;
    exp_order[3] = 4'd3; exp_order[4] = 4'd0;

    rst     = 1'b1;
    ready_i = 1'b1;
    valid_i = 4'b1000;
    data_i  = '0;
    set_port(3, 16'h0055);
    #1;
    check_val("rst_shift", 32'(shift_o), 32'h0);
    check_val("rst_perr", 32'(proto_err_o), 32'h0);
    tick();
    tick();
    check_val("rst_valid", 32'(valid_o), 32'h0);
    check_val("rst_data", 32'(data_o), 32'h0);
    check_val("rst_locked", 32'(locked_o), 32'h0);
    check_val("rst_grant", 32'(grant_o), 32'h0);

    // Single transfer from port 2.
    rst     = 1'b0;
    valid_i = 4'b0100;
    set_port(2, 16'hC0AA);
    #1;
    check_val("single_shift", 32'(shift_o), 32'h4);
    tick();
    check_val("single_data", 32'(data_o), 32'hC0AA);
    check_val("single_valid", 32'(valid_o), 32'h1);
    check_val("single_locked", 32'(locked_o), 32'h0);
    check_val("single_grant", 32'(grant_o), 32'h2);

    // All ports SINGLE: rr_ptr=3 serves port 3 first, then 0,1,2,3,0.
    valid_i = 4'b1111;
    for (int k = 0; k < NUM_IN; k++) set_port(k, 16'hC010 + 16'(k));
    #1;
    check_val("rr_first_shift", 32'(shift_o), 32'h8);
    tick();
    check_val("rr_first_data", 32'(data_o), 32'hC013);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("rr_shift", 32'(shift_o), 32'(4'b0001 << exp_order[i]));
      tick();
      check_val("rr_data", 32'(data_o), 32'hC010 + 32'(exp_order[i]));
      check_val("rr_valid", 32'(valid_o), 32'h1);
    end

    // rr_ptr=1: port 1 HEAD wins over port 0 HEAD and locks.
    valid_i = 4'b0011;
    set_port(0, 16'h8000);
    set_port(1, 16'h8001);
    #1;
    check_val("head_shift", 32'(shift_o), 32'h2);
    tick();
    check_val("head_data", 32'(data_o), 32'h8001);
    check_val("head_locked", 32'(locked_o), 32'h1);
    check_val("head_grant", 32'(grant_o), 32'h1);

    set_port(1, 16'h0002);
    #1;
    check_val("body_shift", 32'(shift_o), 32'h2);
    check_val("body_perr", 32'(proto_err_o), 32'h0);
    tick();
    check_val("body_data", 32'(data_o), 32'h0002);

    // Backpressure mid-packet for 3 cycles.
    set_port(1, 16'h4003);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall_shift", 32'(shift_o), 32'h0);
      tick();
      check_val("stall_data", 32'(data_o), 32'h0002);
      check_val("stall_valid", 32'(valid_o), 32'h1);
    end
    ready_i = 1'b1;
    #1;
    check_val("tail_shift", 32'(shift_o), 32'h2);
    tick();
    check_val("tail_data", 32'(data_o), 32'h4003);
    check_val("tail_locked", 32'(locked_o), 32'h0);
    check_val("tail_grant", 32'(grant_o), 32'h1);

    // Port 0 finally granted after the tail.
    valid_i = 4'b0001;
    #1;
    check_val("p0_shift", 32'(shift_o), 32'h1);
    tick();
    check_val("p0_data", 32'(data_o), 32'h8000);
    check_val("p0_locked", 32'(locked_o), 32'h1);
    check_val("p0_grant", 32'(grant_o), 32'h0);

    // Owner presents another HEAD while locked: error, no pop, output drains.
    #1;
    check_val("lk_perr", 32'(proto_err_o), 32'h1);
    check_val("lk_shift", 32'(shift_o), 32'h0);
    tick();
    check_val("lk_valid", 32'(valid_o), 32'h0);
    check_val("lk_data_hold", 32'(data_o), 32'h8000);
    check_val("lk_still_locked", 32'(locked_o), 32'h1);

    // Reset mid-packet abandons lock and flushes output.
    rst = 1'b1;
    #1;
    check_val("mrst_shift", 32'(shift_o), 32'h0);
    check_val("mrst_perr", 32'(proto_err_o), 32'h0);
    tick();
    rst = 1'b0;
    check_val("mrst_locked", 32'(locked_o), 32'h0);
    check_val("mrst_valid", 32'(valid_o), 32'h0);
    check_val("mrst_data", 32'(data_o), 32'h0);
    valid_i = 4'b1111;
    for (int k = 0; k < NUM_IN; k++) set_port(k, 16'h8020 + 16'(k));
    #1;
    check_val("post_rst_shift", 32'(shift_o), 32'h1);
    tick();
    check_val("post_rst_data", 32'(data_o), 32'h8020);
    check_val("post_rst_locked", 32'(locked_o), 32'h1);

    set_port(0, 16'h4020);
    #1;
    check_val("post_tail_shift", 32'(shift_o), 32'h1);
    tick();
    check_val("post_tail_locked", 32'(locked_o), 32'h0);

    // IDLE with only a stray BODY on port 3.
    valid_i = 4'b1000;
    set_port(3, 16'h0055);
    #1;
    check_val("bad_perr", 32'(proto_err_o), 32'h1);
    check_val("bad_shift", 32'(shift_o), 32'h0);
    tick();
    check_val("bad_valid", 32'(valid_o), 32'h0);
    #1;
    check_val("bad_valid2", 32'(valid_o), 32'h0);

    // Eligible port alongside a stray BODY: no error, rr_ptr=1 wraps to port 0.
    valid_i = 4'b1001;
    set_port(0, 16'hC0BB);
    #1;
    check_val("mix_perr", 32'(proto_err_o), 32'h0);
    check_val("mix_shift", 32'(shift_o), 32'h1);
    tick();
    check_val("mix_data", 32'(data_o), 32'hC0BB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
